// File: rtl/ex_sched.sv
// EX-stage scheduler: tracks in-flight multiplies, detects RAW/WAW and
// writeback-port hazards, and sequences the single writeback port.
module ex_sched #(
  parameter int MUL_DELAY = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       freeze,
  input  logic       issue_valid,
  input  logic       issue_is_mul,
  input  logic       issue_wen,
  input  logic [4:0] issue_rd,
  input  logic [4:0] issue_rs1,
  input  logic [4:0] issue_rs2,
  input  logic       issue_use_rs1,
  input  logic       issue_use_rs2,
  output logic       issue_stall,
  output logic       wb_valid,
  output logic       wb_is_mul,
  output logic [4:0] wb_rd,
  output logic [3:0] mul_inflight
);

  logic [MUL_DELAY:1] stg_vld;
  logic [MUL_DELAY:1] stg_wen;
  logic [4:0]         stg_rd [1:MUL_DELAY];

  logic [MUL_DELAY:1] nxt_vld;
  logic [MUL_DELAY:1] nxt_wen;
  logic               wen_eff;
  logic               raw_hit;
  logic               waw_hit;
  logic               port_busy;
  logic               accept;

  function automatic logic [3:0] count_ones(input logic [MUL_DELAY:1] v);
    logic [3:0] cnt;
    cnt = 4'd0;
    for (int i = 1; i <= MUL_DELAY; i++) begin
      cnt = cnt + {3'd0, v[i]};
    end
    return cnt;
  endfunction

  // Writes to x0 are discarded up front, so they never claim the port or a hazard.
  assign wen_eff   = issue_wen && (issue_rd != 5'd0);
  assign port_busy = stg_vld[MUL_DELAY-1] && stg_wen[MUL_DELAY-1];

  always_comb begin
    raw_hit = 1'b0;
    waw_hit = 1'b0;
    for (int i = 1; i <= MUL_DELAY; i++) begin
      if (stg_vld[i] && stg_wen[i]) begin
        if (issue_use_rs1 && (issue_rs1 != 5'd0) && (issue_rs1 == stg_rd[i])) raw_hit = 1'b1;
        if (issue_use_rs2 && (issue_rs2 != 5'd0) && (issue_rs2 == stg_rd[i])) raw_hit = 1'b1;
        if (wen_eff && (issue_rd == stg_rd[i]))                               waw_hit = 1'b1;
      end
    end
  end

  assign issue_stall = issue_valid &&
                       (raw_hit || waw_hit || (!issue_is_mul && wen_eff && port_busy));
  assign accept      = issue_valid && !issue_stall && !freeze;

  always_comb begin
    nxt_vld    = '0;
    nxt_wen    = '0;
    nxt_vld[1] = accept && issue_is_mul;
    nxt_wen[1] = wen_eff;
    for (int i = 2; i <= MUL_DELAY; i++) begin
      nxt_vld[i] = stg_vld[i-1];
      nxt_wen[i] = stg_wen[i-1];
    end
  end

  // Stage boundary: tracking pipeline control and writeback register
  always_ff @(posedge clk) begin
    if (reset) begin
      stg_vld      <= '0;
      stg_wen      <= '0;
      wb_valid     <= 1'b0;
      wb_is_mul    <= 1'b0;
      wb_rd        <= 5'd0;
      mul_inflight <= 4'd0;
    end else if (!freeze) begin
      stg_vld      <= nxt_vld;
      stg_wen      <= nxt_wen;
      mul_inflight <= count_ones(nxt_vld);
      if (port_busy) begin
        wb_valid  <= 1'b1;
        wb_is_mul <= 1'b1;
        wb_rd     <= stg_rd[MUL_DELAY-1];
      end else if (accept && !issue_is_mul && wen_eff) begin
        wb_valid  <= 1'b1;
        wb_is_mul <= 1'b0;
        wb_rd     <= issue_rd;
      end else begin
        wb_valid  <= 1'b0;
        wb_is_mul <= 1'b0;
        wb_rd     <= 5'd0;
      end
    end
  end

  // Stage boundary: destination indices travel beside the valid bits
  always_ff @(posedge clk) begin
    if (!freeze) begin
      stg_rd[1] <= issue_rd;
      for (int i = 2; i <= MUL_DELAY; i++) begin
        stg_rd[i] <= stg_rd[i-1];
      end
    end
  end

endmodule

// File: tb/tb_ex_sched.sv
// Directed, table-driven bench for ex_sched at MUL_DELAY=4: one record per cycle.
module tb_ex_sched;

  logic       clk = 1'b0;
  logic       reset, freeze;
  logic       issue_valid, issue_is_mul, issue_wen;
  logic [4:0] issue_rd, issue_rs1, issue_rs2;
  logic       issue_use_rs1, issue_use_rs2;
  logic       issue_stall, wb_valid, wb_is_mul;
  logic [4:0] wb_rd;
  logic [3:0] mul_inflight;

  int checks = 0;
  int errors = 0;
  int row_no = 0;

  ex_sched #(.MUL_DELAY(4)) dut (
    .clk(clk), .reset(reset), .freeze(freeze),
    .issue_valid(issue_valid), .issue_is_mul(issue_is_mul), .issue_wen(issue_wen),
    .issue_rd(issue_rd), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_use_rs1(issue_use_rs1), .issue_use_rs2(issue_use_rs2),
    .issue_stall(issue_stall), .wb_valid(wb_valid), .wb_is_mul(wb_is_mul),
    .wb_rd(wb_rd), .mul_inflight(mul_inflight)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit rst, frz, v, m, w;
    int rd, rs1, rs2;
    bit u1, u2, chk;
    bit e_stall, e_wbv, e_wbm;
    int e_wbrd, e_inf;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit rst, bit frz, bit v, bit m, bit w, int rd, int rs1, int rs2,
                              bit u1, bit u2, bit chk, bit es, bit ev, bit em, int erd, int ei);
    vec_t r;
    r.rst = rst; r.frz = frz; r.v = v; r.m = m; r.w = w;
    r.rd = rd; r.rs1 = rs1; r.rs2 = rs2; r.u1 = u1; r.u2 = u2; r.chk = chk;
    r.e_stall = es; r.e_wbv = ev; r.e_wbm = em; r.e_wbrd = erd; r.e_inf = ei;
    return r;
  endfunction

  function automatic vec_t idle(bit ev, bit em, int erd, int ei);
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, ev, em, erd, ei);
  endfunction

  function automatic vec_t mul(int rd, bit ev, bit em, int erd, int ei);
    return mk(0, 0, 1, 1, 1, rd, 0, 0, 0, 0, 1, 0, ev, em, erd, ei);
  endfunction

  function automatic vec_t alu(bit w, int rd, int rs1, bit u1, int rs2, bit u2,
                               bit es, bit ev, bit em, int erd, int ei);
    return mk(0, 0, 1, 0, w, rd, rs1, rs2, u1, u2, 1, es, ev, em, erd, ei);
  endfunction

  function automatic vec_t rst_row(bit frz);
    return mk(1, frz, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL row %0d %s: got %0d, expected %0d", row_no, name, act, exp);
    end
  endtask

  // Drive one cycle's inputs, compare mid-cycle, then advance past the edge.
  task automatic step(input vec_t r);
    reset = r.rst; freeze = r.frz;
    issue_valid = r.v; issue_is_mul = r.m; issue_wen = r.w;
    issue_rd = 5'(r.rd); issue_rs1 = 5'(r.rs1); issue_rs2 = 5'(r.rs2);
    issue_use_rs1 = r.u1; issue_use_rs2 = r.u2;
    #2;
    if (r.chk) begin
      check("issue_stall",  int'(issue_stall),  int'(r.e_stall));
      check("wb_valid",     int'(wb_valid),     int'(r.e_wbv));
      check("wb_is_mul",    int'(wb_is_mul),    int'(r.e_wbm));
      check("wb_rd",        int'(wb_rd),        r.e_wbrd);
      check("mul_inflight", int'(mul_inflight), r.e_inf);
    end
    @(posedge clk);
    #1;
    row_no++;
  endtask

  initial begin
    // reset, then reset-state check
    vecs.push_back(rst_row(0));
    vecs.push_back(rst_row(0));
    // single multiply latency and occupancy
    vecs.push_back(mul(5, 0, 0, 0, 0));
    vecs.push_back(idle(0, 0, 0, 1));
    vecs.push_back(idle(0, 0, 0, 1));
    vecs.push_back(idle(0, 0, 0, 1));
    vecs.push_back(idle(1, 1, 5, 1));
    vecs.push_back(idle(0, 0, 0, 0));
    // writeback port conflict: multiply wins, ALU follows
    vecs.push_back(mul(5, 0, 0, 0, 0));
    vecs.push_back(idle(0, 0, 0, 1));
    vecs.push_back(idle(0, 0, 0, 1));
    vecs.push_back(alu(1, 6, 0, 0, 0, 0, 1, 0, 0, 0, 1));
    vecs.push_back(alu(1, 6, 0, 0, 0, 0, 0, 1, 1, 5, 1));
    vecs.push_back(idle(1, 0, 6, 0));
    vecs.push_back(idle(0, 0, 0, 0));
    // RAW on rs1/rs2 held until the multiply leaves stage 4
    vecs.push_back(mul(7, 0, 0, 0, 0));
    vecs.push_back(alu(1, 8, 7, 1, 0, 0, 1, 0, 0, 0, 1));
    vecs.push_back(alu(1, 8, 0, 0, 7, 1, 1, 0, 0, 0, 1));
    vecs.push_back(alu(1, 8, 7, 1, 0, 0, 1, 0, 0, 0, 1));
    vecs.push_back(alu(1, 8, 7, 1, 0, 0, 1, 1, 1, 7, 1));
    vecs.push_back(alu(1, 8, 7, 1, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(idle(1, 0, 8, 0));
    vecs.push_back(idle(0, 0, 0, 0));
    // rs1 = x0 never hazards
    vecs.push_back(mul(7, 0, 0, 0, 0));
    vecs.push_back(alu(1, 8, 0, 1, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(idle(1, 0, 8, 1));
    vecs.push_back(idle(0, 0, 0, 1));
    vecs.push_back(idle(1, 1, 7, 1));
    vecs.push_back(idle(0, 0, 0, 0));
    // WAW, unused operands, and issue_valid=0 never stalls
    vecs.push_back(mul(9, 0, 0, 0, 0));
    vecs.push_back(alu(1, 9, 0, 0, 0, 0, 1, 0, 0, 0, 1));
    vecs.push_back(alu(0, 9, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(alu(0, 10, 0, 0, 9, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 9, 9, 9, 1, 1, 1, 0, 1, 1, 9, 1));
    vecs.push_back(idle(0, 0, 0, 0));
    // x0 destinations never write back
    vecs.push_back(mul(0, 0, 0, 0, 0));
    vecs.push_back(alu(1, 0, 0, 1, 0, 1, 0, 0, 0, 0, 1));
    vecs.push_back(idle(0, 0, 0, 1));
    vecs.push_back(idle(0, 0, 0, 1));
    vecs.push_back(idle(0, 0, 0, 1));
    vecs.push_back(idle(0, 0, 0, 0));
    // freeze in cycles 2-3 delays writeback to cycle 6, frozen ALU is dropped
    vecs.push_back(mul(5, 0, 0, 0, 0));
    vecs.push_back(idle(0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 1, 0, 1, 12, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1));
    vecs.push_back(idle(0, 0, 0, 1));
    vecs.push_back(idle(0, 0, 0, 1));
    vecs.push_back(idle(1, 1, 5, 1));
    vecs.push_back(idle(0, 0, 0, 0));
    // back-to-back multiplies retire in order
    vecs.push_back(mul(1, 0, 0, 0, 0));
    vecs.push_back(mul(2, 0, 0, 0, 1));
    vecs.push_back(mul(3, 0, 0, 0, 2));
    vecs.push_back(mul(4, 0, 0, 0, 3));
    vecs.push_back(idle(1, 1, 1, 4));
    vecs.push_back(idle(1, 1, 2, 3));
    vecs.push_back(idle(1, 1, 3, 2));
    vecs.push_back(idle(1, 1, 4, 1));
    vecs.push_back(idle(0, 0, 0, 0));
    // reset (with freeze) discards in-flight multiplies
    vecs.push_back(mul(1, 0, 0, 0, 0));
    vecs.push_back(mul(2, 0, 0, 0, 1));
    vecs.push_back(rst_row(1));
    vecs.push_back(alu(1, 3, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(idle(1, 0, 3, 0));
    vecs.push_back(idle(0, 0, 0, 0));
    vecs.push_back(idle(0, 0, 0, 0));
    vecs.push_back(idle(0, 0, 0, 0));

    @(posedge clk);
    #1;
    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i]);
    end

    // freeze while a multiply writeback is on the port: outputs hold
    step(mul(11, 0, 0, 0, 0));
    step(idle(0, 0, 0, 1));
    step(idle(0, 0, 0, 1));
    step(idle(0, 0, 0, 1));
    step(mk(0, 1, 1, 0, 1, 12, 11, 0, 1, 0, 1, 1, 1, 1, 11, 1));
    step(idle(1, 1, 11, 1));
    step(idle(0, 0, 0, 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
